// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline stages.
package mips_pkg;

   localparam int INSTR_W = 32;

   localparam logic [INSTR_W-1:0] NOP = 32'h0;

   typedef enum logic [1:0] {
      S_BOOT,
      S_RUN,
      S_HALT
   } fetch_state_t;

   localparam logic [1:0] CAUSE_NONE     = 2'b00;
   localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
   localparam logic [1:0] CAUSE_RANGE    = 2'b10;

   typedef struct packed {
      logic               valid;
      logic [INSTR_W-1:0] instruction;
      logic [31:0]        pc;
      logic [31:0]        pc_plus4;
   } if_id_t;

endpackage

// File: rtl/mips_fetch_stage_if_id_reg.sv
// IF/ID pipeline register with hold and invalidate controls.
// Invalidate clears valid and instruction only; the PC fields keep their value.
module if_id_reg
   import mips_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               hold,
   input  logic               invalidate,
   input  logic               capture_valid,
   input  logic [INSTR_W-1:0] capture_instruction,
   input  logic [31:0]        capture_pc,
   input  logic [31:0]        capture_pc_plus4,
   output logic               valid,
   output logic [INSTR_W-1:0] instruction,
   output logic [31:0]        pc,
   output logic [31:0]        pc_plus4
);

   if_id_t r_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_q <= '0;
      end else if (invalidate) begin
         r_q.valid       <= 1'b0;
         r_q.instruction <= NOP;
      end else if (!hold) begin
         r_q.valid       <= capture_valid;
         r_q.instruction <= capture_instruction;
         r_q.pc          <= capture_pc;
         r_q.pc_plus4    <= capture_pc_plus4;
      end
   end

   assign valid       = r_q.valid;
   assign instruction = r_q.instruction;
   assign pc          = r_q.pc;
   assign pc_plus4    = r_q.pc_plus4;

endmodule

// File: rtl/mips_fetch_stage.sv
// MIPS instruction-fetch stage: PC, next-PC, fault FSM, IF/ID register.
// FETCH_PERF_CNT_EN adds fetch/stall/redirect performance counters.
module mips_fetch_stage
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          IMEM_DEPTH = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        flush,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_instruction,
   output logic [31:0] pc,
   output logic        if_id_valid,
   output logic [31:0] if_id_instruction,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_pc_plus4,
   output logic        fault,
   output logic [1:0]  fault_cause
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] fetch_count,
   output logic [31:0] stall_count,
   output logic [31:0] redirect_count
`endif
);

   fetch_state_t state_q, state_d;

   logic [31:0] pc_q, pc_d;
   logic [31:0] pc_plus4;
   logic        fault_q, fault_d;
   logic [1:0]  cause_q, cause_d;

   logic        misaligned;
   logic        out_of_range;
   logic        redir_bad;
   logic        redir_ok;
   logic        range_bad;
   logic        run_stall;
   logic        run_fetch;

   logic               ifid_hold;
   logic               ifid_inval;
   logic               cap_valid;
   logic [INSTR_W-1:0] cap_instr;

   assign pc_plus4  = pc_q + 32'd4;
   assign imem_addr = {2'b00, pc_q[31:2]};

   assign misaligned   = |redirect_target[1:0];
   assign out_of_range = imem_addr >= 32'(IMEM_DEPTH);

   // One-hot decode of the S_RUN priority chain
   assign redir_bad = redirect_valid & misaligned;
   assign redir_ok  = redirect_valid & ~misaligned;
   assign range_bad = ~redirect_valid & out_of_range;
   assign run_stall = ~redirect_valid & ~out_of_range & stall;
   assign run_fetch = ~redirect_valid & ~out_of_range & ~stall;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      fault_d    = fault_q;
      cause_d    = cause_q;
      ifid_hold  = 1'b1;
      ifid_inval = 1'b0;
      cap_valid  = 1'b0;
      cap_instr  = NOP;
      unique case (state_q)
         S_BOOT: begin
            state_d = S_RUN;
         end
         S_RUN: begin
            unique case (1'b1)
               redir_bad: begin
                  fault_d    = 1'b1;
                  cause_d    = CAUSE_MISALIGN;
                  state_d    = S_HALT;
                  ifid_inval = 1'b1;
               end
               redir_ok: begin
                  pc_d       = redirect_target;
                  ifid_inval = 1'b1;
               end
               range_bad: begin
                  fault_d    = 1'b1;
                  cause_d    = CAUSE_RANGE;
                  state_d    = S_HALT;
                  ifid_inval = 1'b1;
               end
               run_stall: begin
                  ifid_inval = flush;
               end
               run_fetch: begin
                  pc_d      = pc_plus4;
                  ifid_hold = 1'b0;
                  cap_valid = ~flush;
                  cap_instr = flush ? NOP : imem_instruction;
               end
               default: ;
            endcase
         end
         S_HALT: ;
         default: state_d = S_BOOT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_BOOT;
         pc_q    <= RESET_PC;
         fault_q <= 1'b0;
         cause_q <= CAUSE_NONE;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         fault_q <= fault_d;
         cause_q <= cause_d;
      end
   end

   if_id_reg u_if_id (
      .clk                 (clk),
      .reset               (reset),
      .hold                (ifid_hold),
      .invalidate          (ifid_inval),
      .capture_valid       (cap_valid),
      .capture_instruction (cap_instr),
      .capture_pc          (pc_q),
      .capture_pc_plus4    (pc_plus4),
      .valid               (if_id_valid),
      .instruction         (if_id_instruction),
      .pc                  (if_id_pc),
      .pc_plus4            (if_id_pc_plus4)
   );

   assign pc          = pc_q;
   assign fault       = fault_q;
   assign fault_cause = cause_q;

`ifdef FETCH_PERF_CNT_EN
   logic in_run;
   logic [31:0] fetch_cnt_q;
   logic [31:0] stall_cnt_q;
   logic [31:0] redir_cnt_q;

   assign in_run = state_q == S_RUN;

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_cnt_q <= '0;
         stall_cnt_q <= '0;
         redir_cnt_q <= '0;
      end else begin
         if (in_run && run_fetch && !flush)
            fetch_cnt_q <= fetch_cnt_q + 32'd1;
         if (in_run && stall && !redirect_valid)
            stall_cnt_q <= stall_cnt_q + 32'd1;
         if (in_run && redir_ok)
            redir_cnt_q <= redir_cnt_q + 32'd1;
      end
   end

   assign fetch_count    = fetch_cnt_q;
   assign stall_count    = stall_cnt_q;
   assign redirect_count = redir_cnt_q;
`endif

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Scoreboard bench for mips_fetch_stage against a cycle-level reference model.
module tb_mips_fetch_stage;

   localparam int DEPTH = 256;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_target = '0;
   logic [31:0] imem_addr;
   logic [31:0] imem_instruction;
   logic [31:0] pc;
   logic        if_id_valid;
   logic [31:0] if_id_instruction;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_pc_plus4;
   logic        fault;
   logic [1:0]  fault_cause;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_count;
   logic [31:0] stall_count;
   logic [31:0] redirect_count;
`endif

   logic [31:0] imem [DEPTH];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign imem_instruction = (imem_addr < DEPTH) ?
                             imem[imem_addr[7:0]] : 32'hDEAD_BEEF;

   mips_fetch_stage #(
      .RESET_PC   (32'h0),
      .IMEM_DEPTH (DEPTH)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .stall             (stall),
      .flush             (flush),
      .redirect_valid    (redirect_valid),
      .redirect_target   (redirect_target),
      .imem_addr         (imem_addr),
      .imem_instruction  (imem_instruction),
      .pc                (pc),
      .if_id_valid       (if_id_valid),
      .if_id_instruction (if_id_instruction),
      .if_id_pc          (if_id_pc),
      .if_id_pc_plus4    (if_id_pc_plus4),
      .fault             (fault),
      .fault_cause       (fault_cause)
`ifdef FETCH_PERF_CNT_EN
      ,
      .fetch_count       (fetch_count),
      .stall_count       (stall_count),
      .redirect_count    (redirect_count)
`endif
   );

   typedef struct {
      logic [31:0] pc;
      logic        valid;
      logic [31:0] instr;
      logic [31:0] ipc;
      logic [31:0] ipc4;
      logic        chk_ipc;
      logic        fault;
      logic [1:0]  cause;
      logic [31:0] nf;
      logic [31:0] ns;
      logic [31:0] nr;
   } exp_t;

   exp_t exp_q[$];
   exp_t m;
   bit   m_live;
   bit   m_halt;

   // Reference model: one call per clock edge with that edge's inputs
   task automatic model_step(input logic r, s, f, rv,
                             input logic [31:0] rt);
      if (r) begin
         m = '{pc: 32'h0, valid: 0, instr: 0, ipc: 0, ipc4: 0,
               chk_ipc: 1, fault: 0, cause: 0,
               nf: 0, ns: 0, nr: 0};
         m_live = 0;
         m_halt = 0;
      end else if (!m_live) begin
         m_live = 1;
      end else if (!m_halt) begin
         if (s && !rv) m.ns++;
         if (rv && (rt % 4) != 0) begin
            m.fault = 1; m.cause = 2'd1; m_halt = 1;
            m.valid = 0; m.instr = 0; m.chk_ipc = 0;
         end else if (rv) begin
            m.pc = rt; m.nr++;
            m.valid = 0; m.instr = 0; m.chk_ipc = 0;
         end else if (m.pc / 4 >= DEPTH) begin
            m.fault = 1; m.cause = 2'd2; m_halt = 1;
            m.valid = 0; m.instr = 0; m.chk_ipc = 0;
         end else if (s) begin
            if (f) begin
               m.valid = 0; m.instr = 0; m.chk_ipc = 0;
            end
         end else begin
            m.valid = !f;
            m.instr = f ? 32'h0 : imem[m.pc / 4];
            m.ipc = m.pc;
            m.ipc4 = m.pc + 4;
            m.chk_ipc = !f;
            if (!f) m.nf++;
            m.pc = m.pc + 4;
         end
      end
   endtask

   task automatic cyc(input logic r, s, f, rv,
                      input logic [31:0] rt);
      reset = r;
      stall = s;
      flush = f;
      redirect_valid = rv;
      redirect_target = rt;
      model_step(r, s, f, rv, rt);
      exp_q.push_back(m);
      @(posedge clk);
      #2;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 32'h0);
   endtask

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s actual=%h required=%h t=%0t",
                  name, act, want, $time);
      end
   endtask

   exp_t e;

   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("pc", pc, e.pc);
         check("imem_addr", imem_addr, e.pc >> 2);
         check("valid", 32'(if_id_valid), 32'(e.valid));
         check("instr", if_id_instruction, e.instr);
         check("fault", 32'(fault), 32'(e.fault));
         check("cause", 32'(fault_cause), 32'(e.cause));
         if (e.chk_ipc) begin
            check("if_id_pc", if_id_pc, e.ipc);
            check("if_id_pc4", if_id_pc_plus4, e.ipc4);
         end
`ifdef FETCH_PERF_CNT_EN
         check("fetch_count", fetch_count, e.nf);
         check("stall_count", stall_count, e.ns);
         check("redirect_count", redirect_count, e.nr);
`endif
      end
   end

   initial begin
      for (int k = 0; k < DEPTH; k++) imem[k] = 32'h1000_0000 + k;

      cyc(1, 0, 0, 0, 32'h0);
      cyc(1, 0, 0, 0, 32'h0);
      run(3);
      for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 32'h0);
      run(2);
      cyc(0, 1, 0, 1, 32'h40);
      run(3);
      cyc(0, 0, 0, 1, 32'h42);
      run(3);

      cyc(1, 0, 0, 0, 32'h0);
      run(260);
      cyc(0, 1, 1, 1, 32'h8);

      cyc(1, 0, 0, 0, 32'h0);
      run(5);
      cyc(0, 0, 1, 0, 32'h0);
      run(2);
      cyc(0, 1, 1, 0, 32'h0);
      run(2);

      for (int i = 0; i < 4000; i++) begin
         logic r, s, f, rv;
         logic [31:0] rt;
         r  = $urandom_range(0, 99) < 2;
         s  = $urandom_range(0, 99) < 25;
         f  = $urandom_range(0, 99) < 10;
         rv = $urandom_range(0, 99) < 6;
         rt = 32'($urandom_range(0, 270)) << 2;
         if ($urandom_range(0, 9) == 0)
            rt[1:0] = 2'($urandom_range(1, 3));
         cyc(r, s, f, rv, rt);
      end

      @(posedge clk);
      #3;
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mips_fetch_stage.md
Name: mips_fetch_stage

Overview:
- Instruction-fetch stage of the 32-bit MIPS core.
- Holds the PC and computes the next PC.
- Drives the word address into the combinational instruction memory.
- Captures the returned instruction into the IF/ID pipeline register consumed by decode.
- Handles stall and flush from the hazard unit, redirect from branch/jump resolution, and fatal fetch faults.

Parameters:
- RESET_PC, 32'h0000_0000, byte address loaded into the PC on reset.
- IMEM_DEPTH, 256, instruction memory depth in 32-bit words; a fetch at word index >= IMEM_DEPTH is a range fault.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hold the PC and the IF/ID register this cycle.
- flush  input  1  invalidate the IF/ID register at this edge.
- redirect_valid  input  1  load the PC from redirect_target.
- redirect_target  input  32  byte address of the branch/jump target.
- imem_addr  output  32  word index to instruction memory (pc >> 2), combinational from the PC.
- imem_instruction  input  32  instruction word returned combinationally for imem_addr.
- pc  output  32  current fetch PC, byte address.
- if_id_valid  output  1  IF/ID holds a real instruction.
- if_id_instruction  output  32  latched instruction; 32'h0 (NOP) when invalid.
- if_id_pc  output  32  byte address of the latched instruction.
- if_id_pc_plus4  output  32  if_id_pc + 4, modulo 2^32.
- fault  output  1  sticky; fetch halted.
- fault_cause  output  2  2'b00 none, 2'b01 misaligned redirect, 2'b10 PC out of range.

Behaviour:
- FSM states: S_BOOT, S_RUN, S_HALT.
- Reset (sampled at the edge, overrides everything, including mid-stall or mid-halt):
  - pc = RESET_PC; state = S_BOOT.
  - if_id_valid = 0; if_id_instruction, if_id_pc and if_id_pc_plus4 = 0.
  - fault = 0; fault_cause = 0.
- S_BOOT:
  - Lasts exactly one cycle; no capture; if_id_valid stays 0.
  - Next state is S_RUN; the PC is not advanced.
  - Inputs are ignored.
- S_RUN, one edge, evaluated in this priority order:
  1. redirect_valid with redirect_target[1:0] != 0:
     - fault = 1, cause 01, state = S_HALT.
     - PC unchanged; IF/ID invalidated.
  2. redirect_valid, aligned:
     - pc <= redirect_target.
     - IF/ID invalidated; the wrong-path instruction is dropped.
     - Applies even when stall = 1.
  3. (pc >> 2) >= IMEM_DEPTH:
     - fault = 1, cause 10, state = S_HALT.
     - IF/ID invalidated.
  4. stall:
     - PC and IF/ID hold, except flush = 1 still invalidates IF/ID.
  5. Otherwise:
     - pc <= pc + 4.
     - Capture if_id_instruction = imem_instruction, if_id_pc = pc, if_id_pc_plus4 = pc + 4.
     - if_id_valid = !flush. When flush = 1, the captured instruction is forced to 0.
- "Invalidated" means if_id_valid = 0 and if_id_instruction = 0. if_id_pc and if_id_pc_plus4 may hold stale values.
- S_HALT:
  - PC frozen; if_id_valid = 0.
  - fault and fault_cause hold until reset.
  - All inputs are ignored.
- Latency: the instruction at pc appears on the if_id_* outputs one cycle after pc is presented.
- Throughput: one instruction per cycle when unstalled.
- PC arithmetic is 32-bit unsigned and wraps modulo 2^32; the range check normally halts fetch before wrap.
- The PC is always word-aligned, since RESET_PC must be aligned.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: adds 32-bit outputs fetch_count (valid captures), stall_count (cycles in S_RUN with stall = 1 and no redirect) and redirect_count (accepted aligned redirects).
  - Counters clear on reset and wrap modulo 2^32.
  - They freeze in S_HALT.
- Undefined: these ports and registers are absent; all other behaviour is identical.

Decomposition:
- Shared package mips_pkg holds:
  - FSM state typedef (S_BOOT, S_RUN, S_HALT).
  - fault_cause encodings.
  - NOP constant 32'h0.
  - Instruction width constant 32.
- Sub-module if_id_reg: the IF/ID pipeline register with hold and invalidate controls. It is reused by later pipeline registers.
- Next-PC logic and the FSM stay in the top module.

Test Plan:
- Reset with RESET_PC = 0, imem[k] = 32'h1000_0000 + k:
  - Cycle 1 valid = 0 (BOOT).
  - Cycle 2 on: if_id_instruction = 32'h1000_0000, 32'h1000_0001, ... with if_id_pc = 0, 4, 8.
- Stall asserted for 3 cycles at pc = 8: pc and if_id_* hold for 3 cycles, then resume with instruction 32'h1000_0002 at pc 8.
- Aligned redirect to 32'h40 while stall = 1:
  - Next cycle pc = 32'h40 and if_id_valid = 0.
  - Following cycle if_id_instruction = 32'h1000_0010, if_id_pc = 32'h40.
- Redirect to 32'h42: fault = 1, cause 2'b01, valid stays 0, pc frozen until reset.
- Sequential fetch to pc = 32'h3FC, then advance: pc = 32'h400 gives fault cause 2'b10 and a halt.
- flush with no stall at pc = 32'h10: if_id_valid = 0, if_id_instruction = 0, pc advances to 32'h14. Reset asserted in S_HALT returns to S_BOOT with fault = 0.
